// File: rtl/div_radix2_seq_pkg.sv
// +----------------------------------------------------------------------------+
// | div_radix2_seq_pkg : shared width default and FSM state encoding            |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

package div_radix2_seq_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

`default_nettype wire

// File: rtl/div_radix2_seq_if.sv
// +----------------------------------------------------------------------------+
// | div_radix2_seq_if : divide start/ready handshake between EX control and     |
// | the divider. Revision 1.0                                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

interface div_radix2_seq_if #(
  parameter int WIDTH = 32
);

  logic                 start;
  logic                 signed_div;
  logic [WIDTH-1:0]     opa;
  logic [WIDTH-1:0]     opb;
  logic                 annul;
  logic                 ready;
  logic [2*WIDTH-1:0]   result;

  modport master (
    output start, signed_div, opa, opb, annul,
    input  ready, result
  );

  modport slave (
    input  start, signed_div, opa, opb, annul,
    output ready, result
  );

endinterface

`default_nettype wire

// File: rtl/div_radix2_seq_sign_fix.sv
// +----------------------------------------------------------------------------+
// | div_sign_fix : conditional two's-complement negate (abs / sign fixup)       |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module div_sign_fix
  import div_radix2_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  assign dout = neg ? (~din + WIDTH'(1)) : din;

endmodule

`default_nettype wire

// File: rtl/div_radix2_seq.sv
// +----------------------------------------------------------------------------+
// | div_radix2_seq : multi-cycle restoring radix-2 divider, {rem, quo} result.  |
// | Optional macro DIV_FAST_ZERO_EN: zero divisor completes in one cycle.       |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module div_radix2_seq
  import div_radix2_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  div_radix2_seq_if.slave  bus
);

  localparam int            CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  div_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]       rem_q, rem_d;
  logic [WIDTH-1:0]       dvd_q, dvd_d;
  logic [WIDTH-1:0]       dvs_q, dvs_d;
  logic                   sign_q_q, sign_q_d;
  logic                   sign_r_q, sign_r_d;
  logic                   ready_q, ready_d;
  logic [2*WIDTH-1:0]     result_q, result_d;

  logic                   neg_a, neg_b;
  logic [WIDTH-1:0]       abs_a, abs_b;
  logic [WIDTH:0]         shifted;
  logic [WIDTH+1:0]       trial;
  logic                   borrow;
  logic [WIDTH-1:0]       rem_step, quo_step;
  logic [WIDTH-1:0]       fix_rem, fix_quo;

  assign neg_a = bus.signed_div & bus.opa[WIDTH-1];
  assign neg_b = bus.signed_div & bus.opb[WIDTH-1];

  div_sign_fix #(.WIDTH(WIDTH)) u_abs_a (.neg(neg_a), .din(bus.opa), .dout(abs_a));
  div_sign_fix #(.WIDTH(WIDTH)) u_abs_b (.neg(neg_b), .din(bus.opb), .dout(abs_b));

  // One restoring step: the extra top bit of trial is the borrow of the
  // WIDTH+1-bit subtract of the divisor from the shifted partial remainder.
  always_comb begin
    shifted  = {rem_q, dvd_q[WIDTH-1]};
    trial    = {1'b0, shifted} - {2'b00, dvs_q};
    borrow   = trial[WIDTH+1];
    rem_step = WIDTH'(borrow ? {1'b0, shifted} : trial);
    quo_step = {dvd_q[WIDTH-2:0], ~borrow};
  end

  div_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (.neg(sign_r_q), .din(rem_step), .dout(fix_rem));
  div_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (.neg(sign_q_q), .din(quo_step), .dout(fix_quo));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    sign_q_d = sign_q_q;
    sign_r_d = sign_r_q;
    ready_d  = 1'b0;
    result_d = result_q;

    case (state_q)
      DIV_IDLE: begin
        if (bus.start) begin
          dvd_d    = abs_a;
          dvs_d    = abs_b;
          rem_d    = '0;
          cnt_d    = '0;
          sign_q_d = bus.signed_div & (bus.opa[WIDTH-1] ^ bus.opb[WIDTH-1]);
          sign_r_d = neg_a;
          state_d  = DIV_CALC;
`ifdef DIV_FAST_ZERO_EN
          if (bus.opb == '0) begin
            state_d  = DIV_DONE;
            ready_d  = 1'b1;
            result_d = {bus.opa, {WIDTH{1'b1}}};
          end
`endif
        end
      end

      DIV_CALC: begin
        rem_d = rem_step;
        dvd_d = quo_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          state_d  = DIV_DONE;
          ready_d  = 1'b1;
          result_d = {fix_rem, fix_quo};
        end
      end

      DIV_DONE: state_d = DIV_IDLE;

      default:  state_d = DIV_IDLE;
    endcase

    // A flush wins over everything, including a start or a final step.
    if (bus.annul) begin
      state_d  = DIV_IDLE;
      ready_d  = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= DIV_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      sign_q_q <= sign_q_d;
      sign_r_q <= sign_r_d;
      ready_q  <= ready_d;
      result_q <= result_d;
    end
  end

  assign bus.ready  = ready_q;
  assign bus.result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_div_radix2_seq.sv
// +----------------------------------------------------------------------------+
// | tb_div_radix2_seq : directed + randomized bench with arithmetic reference   |
// | model and a per-cycle compare process. Revision 1.0                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_div_radix2_seq;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  div_radix2_seq_if #(.WIDTH(W)) bus ();

  div_radix2_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int          compared   = 0;
  int          mismatched = 0;
  int          n_starts   = 0;
  int          n_readys   = 0;
  bit          checking   = 1'b0;
  bit          exp_pending = 1'b0;
  int          exp_cycle  = 0;
  logic [63:0] exp_result = '0;
  logic [63:0] hold       = '0;

  logic [31:0] specials [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};

  // Quotient/remainder from plain division of magnitudes, then sign fixup.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] ma, mb, q, r;
`ifdef DIV_FAST_ZERO_EN
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
`endif
    ma = (s && a[31]) ? -a : a;
    mb = (s && b[31]) ? -b : b;
    if (mb == 32'h0) begin
      q = 32'hFFFF_FFFF;
      r = ma;
    end else begin
      q = ma / mb;
      r = ma % mb;
    end
    if (s && (a[31] ^ b[31])) q = -q;
    if (s && a[31])           r = -r;
    return {r, q};
  endfunction

  function automatic int latency(input logic [31:0] b);
`ifdef DIV_FAST_ZERO_EN
    if (b == 32'h0) return 1;
`endif
    return W + 1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_op();
    int pick;
    pick = $urandom_range(0, 5);
    if (pick == 0) return specials[$urandom_range(0, 5)];
    if (pick == 1) return 32'($urandom_range(0, 15));
    return $urandom;
  endfunction

  // Every cycle: ready only where the model says, result held otherwise.
  always @(negedge clk) begin
    if (checking) begin
      if (exp_pending && cyc == exp_cycle) begin
        chk("ready_pulse", 64'(bus.ready), 64'd1);
        chk("result", bus.result, exp_result);
        if (bus.ready === 1'b1) n_readys++;
        hold        = exp_result;
        exp_pending = 1'b0;
      end else begin
        chk("ready_low", 64'(bus.ready), 64'd0);
        chk("result_hold", bus.result, hold);
        if (bus.ready === 1'b1) n_readys++;
      end
    end
  end

  // Issue one operation starting in the current (IDLE) cycle; returns in the
  // cycle after ready so the next call is back-to-back.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input bit wiggle, input bit annul_done);
    int lat;
    lat = latency(b);
    bus.start      = 1'b1;
    bus.opa        = a;
    bus.opb        = b;
    bus.signed_div = s;
    exp_result     = ref_div(a, b, s);
    exp_cycle      = cyc + lat;
    exp_pending    = 1'b1;
    n_starts++;
    for (int i = 0; i < lat; i++) begin
      tick();
      bus.opa        = $urandom;
      bus.opb        = $urandom;
      bus.signed_div = 1'($urandom);
      if (wiggle) bus.start = 1'($urandom);
    end
    bus.start = 1'b0;
    bus.annul = annul_done;
    tick();
    bus.annul = 1'b0;
  endtask

  // Start an operation and abort it k cycles later by annul or reset.
  task automatic abort_op(input logic [31:0] a, input logic [31:0] b, input int k, input bit by_reset);
    bus.start      = 1'b1;
    bus.opa        = a;
    bus.opb        = b;
    bus.signed_div = 1'b0;
    repeat (k) tick();
    exp_pending = 1'b0;
    if (by_reset) rst = 1'b1;
    else          bus.annul = 1'b1;
    tick();
    rst       = 1'b0;
    bus.annul = 1'b0;
    bus.start = 1'b0;
    if (by_reset) hold = '0;
    tick();
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.signed_div = 1'b0;
    bus.opa        = '0;
    bus.opb        = '0;
    bus.annul      = 1'b0;
    rst            = 1'b1;
    repeat (3) tick();
    rst      = 1'b0;
    hold     = '0;
    checking = 1'b1;

    chk("model_u_7_2",     ref_div(32'd7, 32'd2, 1'b0),                       {32'd1, 32'd3});
    chk("model_s_m7_2",    ref_div(32'hFFFF_FFF9, 32'd2, 1'b1),               {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    chk("model_s_7_m2",    ref_div(32'd7, 32'hFFFF_FFFE, 1'b1),               {32'd1, 32'hFFFF_FFFD});
    chk("model_s_ovf",     ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1),       {32'd0, 32'h8000_0000});
    chk("model_u_ovf",     ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0),       {32'h8000_0000, 32'd0});
    chk("model_u_5_0",     ref_div(32'd5, 32'd0, 1'b0),                       {32'd5, 32'hFFFF_FFFF});

    tick();
    run_op(32'd7,          32'd2,          1'b0, 1'b0, 1'b0);
    run_op(32'hFFFF_FFF9,  32'd2,          1'b1, 1'b0, 1'b0);
    run_op(32'd7,          32'hFFFF_FFFE,  1'b1, 1'b0, 1'b0);
    run_op(32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 1'b0, 1'b0);
    run_op(32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 1'b0, 1'b0);
    run_op(32'd5,          32'd0,          1'b0, 1'b0, 1'b0);
    run_op(32'hFFFF_FFF9,  32'd0,          1'b1, 1'b0, 1'b0);

    abort_op(32'd1000, 32'd7, 10, 1'b0);
    run_op(32'd1000, 32'd3, 1'b0, 1'b0, 1'b0);

    // annul together with start in IDLE must not launch an operation
    bus.start = 1'b1;
    bus.annul = 1'b1;
    bus.opa   = 32'd99;
    bus.opb   = 32'd4;
    tick();
    bus.annul = 1'b0;
    run_op(32'd99, 32'd4, 1'b0, 1'b0, 1'b0);

    run_op(32'hDEAD_BEEF, 32'd17, 1'b1, 1'b0, 1'b1);

    abort_op(32'd12345, 32'd11, 20, 1'b1);
    run_op(32'd12345, 32'd11, 1'b1, 1'b0, 1'b0);

    for (int n = 0; n < 200; n++) begin
      run_op(rand_op(), rand_op(), 1'($urandom), 1'b1, 1'b0);
    end

    repeat (3) tick();
    chk("ready_per_start", 64'(n_readys), 64'(n_starts));
    chk("no_pending", 64'(exp_pending), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/div_radix2_seq.md
Name: div_radix2_seq

Overview:
- Multi-cycle restoring (radix-2) integer divider in the EX stage.
- Responder side of the divide start/ready handshake: EX-stage control holds `start` high while a DIV/DIVU is in EX and `ready` is low.
- Produces quotient (LO) and remainder (HI) for the HI/LO write path.
- Handles signed and unsigned operands, pipeline flush (annul) and synchronous reset.

Parameters:
- WIDTH, 32, operand width in bits; the result is 2*WIDTH bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  divide request; level-held by the requester until `ready` pulses.
- signed_div  input  1  1 = DIV (signed), 0 = DIVU; sampled with `start` in IDLE.
- opa  input  WIDTH  dividend; sampled in IDLE.
- opb  input  WIDTH  divisor; sampled in IDLE.
- annul  input  1  flush/exception; abandons any operation in progress.
- ready  output  1  one-cycle pulse; `result` is valid in this cycle.
- result  output  2*WIDTH  {remainder, quotient}; held until the next operation completes.

Behaviour:
- Reset (clk edge with rst=1):
  - state=IDLE, ready=0, result=0, counter=0.
  - Reset mid-operation discards all work.
- States:
  - IDLE: on start=1 and annul=0:
    - latch |opa| and |opb| (absolute values only when signed_div=1);
    - latch sign_q = opa[msb]^opb[msb] and sign_r = opa[msb] (both forced to 0 when unsigned);
    - clear the partial remainder; counter=0; go to CALC.
  - CALC: one restoring step per cycle:
    - shift {rem, dvd} left by 1;
    - trial-subtract the divisor from rem using a WIDTH+1-bit subtract;
    - if no borrow, rem = difference and the quotient bit = 1;
    - counter increments; after WIDTH steps go to DONE.
  - DONE:
    - ready=1 for exactly this cycle;
    - result = {sign-fixed remainder, sign-fixed quotient}, registered on entry to DONE;
    - next state is IDLE unconditionally.
- Latency:
  - start first high in cycle 0 (IDLE);
  - CALC occupies cycles 1..WIDTH;
  - ready=1 in cycle WIDTH+1 (cycle 33 for WIDTH=32).
- Back-to-back: a new start is only accepted in IDLE, so the earliest restart is the cycle after DONE. The requester drops start while ready=1.
- Sign fixup:
  - quotient is negated if sign_q; remainder is negated if sign_r;
  - arithmetic is two's complement, wrapping modulo 2^WIDTH.
- Overflow case: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (wrap, no trap).
- Divide by zero (macro absent): the normal WIDTH-step run gives quotient=all-ones and remainder=|dividend|, then sign fixup is applied.
- annul:
  - annul=1 in any state forces IDLE next cycle with ready=0; result is unchanged.
  - annul takes priority over start in the same cycle.
  - annul in the DONE cycle suppresses nothing: ready is already out and result has been written.
- start dropping during CALC without annul is ignored; the operation runs to completion.

Optional Feature:
- DIV_FAST_ZERO_EN defined:
  - a zero divisor sampled in IDLE skips CALC and goes straight to DONE (ready in cycle 1);
  - result = {opa, all-ones} as raw values, with no sign fixup.
- Undefined: divide by zero takes the full WIDTH+1 latency with the natural restoring result described above.

Decomposition:
- defines.vh holds:
  - state encodings DIV_IDLE/DIV_CALC/DIV_DONE (2-bit);
  - DIV_WIDTH default 32;
  - the macro DIV_FAST_ZERO_EN (commented out by default).
- One natural sub-module: div_sign_fix (combinational conditional two's-complement negate, WIDTH bits).
  - Instanced for operand abs (x2) and for result fixup (x2).

Test Plan:
- Unsigned 7/2: opa=7, opb=2, signed_div=0, start held -> ready only in cycle 33; result={1, 3}; ready low in cycles 1..32 and 34.
- Signed -7/2: opa=0xFFFFFFF9, opb=2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7/-2 -> quotient 0xFFFFFFFD, remainder 1.
- Overflow: signed 0x80000000/0xFFFFFFFF -> result={0, 0x80000000}. Unsigned same operands -> {0x80000000, 0}.
- Flush and reset mid-operation:
  - annul=1 at cycle 10 -> IDLE at cycle 11, no ready pulse, result retains its previous value; a new start at cycle 12 completes correctly at cycle 45.
  - rst at cycle 20 -> ready=0 and result=0.
- Divide by zero, unsigned 5/0:
  - macro undefined -> ready cycle 33, result={5, 0xFFFFFFFF};
  - DIV_FAST_ZERO_EN defined -> ready cycle 1, same result.
- Randomized back-to-back signed/unsigned operations (start re-asserted the cycle after ready) against a reference model: every result matches and exactly one ready per accepted start.
